// File: rtl/root5_rr_arbiter_if.sv
// Bundle of request/grant signals between five requesters and the
// round-robin arbiter. The arbiter connects through the slave modport; the
// requester side (or a testbench) connects through the master modport.
interface root5_rr_arbiter_if;
  logic [4:0] req;
  logic [4:0] done;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout_pulse;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout_pulse
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output timeout_pulse
  );
endinterface

// File: rtl/root5_rr_arbiter.sv
// Five-way round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner pulses done or drops its request, and one
// idle cycle always separates consecutive grants. After reset requester 0 has
// first priority.
// Optional feature: define ROOT5_ARB_TIMEOUT_EN to force a release after
// MAX_HOLD grant cycles, flagged by a one-cycle timeout_pulse. Without the
// macro grants are held indefinitely and timeout_pulse stays low.
module root5_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  root5_rr_arbiter_if.slave     bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // MAX_HOLD has to fit the 8-bit hold counter and allow at least two cycles.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_badMaxHold
    $error("root5_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  logic [0:0] r_state;
  logic [4:0] r_gnt;
  logic [2:0] r_gntId;
  logic [2:0] r_lastId;

  logic       w_found;
  logic [2:0] w_pickId;
  logic [2:0] w_cand;
  logic       w_normalRelease;
  logic       w_forceRelease;

  // Indices only ever take the values 0..4, so wrap 4 back to 0.
  function automatic logic [2:0] nextId(input logic [2:0] id);
    nextId = (id >= 3'd4) ? 3'd0 : id + 3'd1;
  endfunction

  // Scan requesters starting just after the last winner, wrapping modulo 5.
  always_comb begin
    w_found  = 1'b0;
    w_pickId = 3'd0;
    w_cand   = nextId(r_lastId);
    for (int k = 0; k < 5; k++) begin
      if (!w_found && bus.req[w_cand]) begin
        w_found  = 1'b1;
        w_pickId = w_cand;
      end
      w_cand = nextId(w_cand);
    end
  end

  // Only the current owner's done or request line can end its grant.
  always_comb begin
    w_normalRelease = 1'b0;
    if (r_state == ST_GRANT) begin
      w_normalRelease = bus.done[r_gntId] | ~bus.req[r_gntId];
    end
  end

`ifdef ROOT5_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  logic [7:0] r_holdCnt;
  logic       r_timeoutPulse;

  // A normal release in the limit cycle wins, so no pulse is raised then.
  assign w_forceRelease = (r_state == ST_GRANT) && (r_holdCnt == HOLD_LIMIT)
                          && !w_normalRelease;

  // Count grant cycles from 1 and flag the cycle right after a forced release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_holdCnt      <= 8'd0;
      r_timeoutPulse <= 1'b0;
    end else begin
      r_timeoutPulse <= w_forceRelease;
      if (r_state == ST_IDLE) begin
        r_holdCnt <= w_found ? 8'd1 : 8'd0;
      end else if (w_normalRelease || w_forceRelease) begin
        r_holdCnt <= 8'd0;
      end else begin
        r_holdCnt <= r_holdCnt + 8'd1;
      end
    end
  end

  assign bus.timeout_pulse = r_timeoutPulse;
`else
  assign w_forceRelease    = 1'b0;
  assign bus.timeout_pulse = 1'b0;
`endif

  // Two-state grant FSM; leaving GRANT always passes through IDLE once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= 5'd0;
      r_gntId  <= 3'd0;
      r_lastId <= 3'd4;
    end else if (r_state == ST_IDLE) begin
      if (w_found) begin
        r_state  <= ST_GRANT;
        r_gnt    <= 5'd1 << w_pickId;
        r_gntId  <= w_pickId;
        r_lastId <= w_pickId;
      end
    end else begin
      if (w_normalRelease || w_forceRelease) begin
        r_state <= ST_IDLE;
        r_gnt   <= 5'd0;
        r_gntId <= 3'd0;
      end
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.gnt_id = r_gntId;
  assign bus.busy   = |r_gnt;

endmodule

// File: tb/tb_root5_rr_arbiter.sv
// Directed bench for root5_rr_arbiter: a table of per-cycle vectors covering
// reset, round-robin rotation, release rules and mid-grant reset, followed by
// hand-written hold/timeout sequences (which depend on ROOT5_ARB_TIMEOUT_EN).
module tb_root5_rr_arbiter;

  typedef struct {
    logic       rstN;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] expGnt;
    logic [2:0] expId;
    logic       expBusy;
    logic       expPulse;
  } vec_t;

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFails;
  vec_t vecs[$];

  root5_rr_arbiter_if arbIf();

  root5_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arbIf)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic [4:0] q, input logic [4:0] d,
                        input logic [4:0] g, input logic [2:0] id, input logic p);
    vec_t v;
    v.rstN     = r;
    v.req      = q;
    v.done     = d;
    v.expGnt   = g;
    v.expId    = id;
    v.expBusy  = |g;
    v.expPulse = p;
    vecs.push_back(v);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the
  // next falling edge so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic r, input logic [4:0] q, input logic [4:0] d);
    rst_n      = r;
    arbIf.req  = q;
    arbIf.done = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] eGnt,
                             input logic [2:0] eId, input logic eBusy, input logic ePulse);
    numChecks++;
    if ({arbIf.gnt, arbIf.gnt_id, arbIf.busy, arbIf.timeout_pulse}
        !== {eGnt, eId, eBusy, ePulse}) begin
      numFails++;
      $display("[TB] FAIL %s: got gnt=%b id=%0d busy=%b pulse=%b, expected gnt=%b id=%0d busy=%b pulse=%b",
               name, arbIf.gnt, arbIf.gnt_id, arbIf.busy, arbIf.timeout_pulse,
               eGnt, eId, eBusy, ePulse);
    end
  endtask

  initial begin
    numChecks  = 0;
    numFails   = 0;
    rst_n      = 1'b0;
    arbIf.req  = 5'd0;
    arbIf.done = 5'd0;

    //      rstN  req       done      expGnt    id    pulse
    addVec(1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0); // reset state
    addVec(1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd0, 1'b0); // req ignored in reset
    addVec(1'b1, 5'b11111, 5'b00000, 5'b00001, 3'd0, 1'b0); // first grant to 0
    addVec(1'b1, 5'b11111, 5'b00001, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b11111, 5'b00000, 5'b00010, 3'd1, 1'b0);
    addVec(1'b1, 5'b11111, 5'b00010, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b11111, 5'b00000, 5'b00100, 3'd2, 1'b0);
    addVec(1'b1, 5'b11111, 5'b00100, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b11111, 5'b00000, 5'b01000, 3'd3, 1'b0);
    addVec(1'b1, 5'b11111, 5'b01000, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b11111, 5'b00000, 5'b10000, 3'd4, 1'b0);
    addVec(1'b1, 5'b11111, 5'b10000, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b11111, 5'b00000, 5'b00001, 3'd0, 1'b0); // wraps back to 0
    addVec(1'b1, 5'b11111, 5'b00001, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b0); // single requester 2
    addVec(1'b1, 5'b00100, 5'b00100, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b00010, 5'b00000, 5'b00010, 3'd1, 1'b0); // grant to 1
    addVec(1'b1, 5'b11111, 5'b11101, 5'b00010, 3'd1, 1'b0); // foreign done ignored
    addVec(1'b1, 5'b11101, 5'b00000, 5'b00000, 3'd0, 1'b0); // req[1] dropped
    addVec(1'b1, 5'b11101, 5'b00000, 5'b00100, 3'd2, 1'b0); // rotation from 1
    addVec(1'b1, 5'b11001, 5'b00000, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b11001, 5'b00000, 5'b01000, 3'd3, 1'b0); // grant to 3
    addVec(1'b0, 5'b11001, 5'b00000, 5'b00000, 3'd0, 1'b0); // reset mid-grant
    addVec(1'b1, 5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b0);
    addVec(1'b1, 5'b01000, 5'b01000, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b0); // same requester again
    addVec(1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);
    addVec(1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0); // stays idle
    addVec(1'b1, 5'b00101, 5'b00000, 5'b00001, 3'd0, 1'b0); // from 4 wraps to 0
    addVec(1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0);

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGnt, vecs[i].expId,
                  vecs[i].expBusy, vecs[i].expPulse);
    end

`ifdef ROOT5_ARB_TIMEOUT_EN
    applyStimulus(1'b1, 5'b00001, 5'b00000);
    checkOutput("to_hold1", 5'b00001, 3'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      applyStimulus(1'b1, 5'b00001, 5'b00000);
      checkOutput($sformatf("to_hold%0d", c), 5'b00001, 3'd0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 5'b00001, 5'b00000);
    checkOutput("to_forced", 5'b00000, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'b00001, 5'b00000);
    checkOutput("to_regrant", 5'b00001, 3'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      applyStimulus(1'b1, 5'b00001, 5'b00000);
      checkOutput($sformatf("co_hold%0d", c), 5'b00001, 3'd0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 5'b00001, 5'b00001);
    checkOutput("co_release", 5'b00000, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'b00000, 5'b00000);
    checkOutput("co_after", 5'b00000, 3'd0, 1'b0, 1'b0);
`else
    applyStimulus(1'b1, 5'b00001, 5'b00000);
    checkOutput("hold_start", 5'b00001, 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 5'b00001, 5'b00000);
      checkOutput($sformatf("hold%0d", c), 5'b00001, 3'd0, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 5'b00000, 5'b00000);
    checkOutput("hold_release", 5'b00000, 3'd0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/root5_rr_arbiter.md
ROOT5_RR_ARBITER -- requirements
Module: root5_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of cycles a grant is held when the timeout feature is compiled in (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port req  input  5  per-requester request lines, one per sub-instance 0..4.
REQ-005 SHALL have port done  input  5  per-requester release strobes.
REQ-006 SHALL have port gnt  output  5  one-hot grant, registered.
REQ-007 SHALL have port gnt_id  output  3  index of the granted requester (0..4), registered.
REQ-008 SHALL have port busy  output  1  high while any grant is held.
REQ-009 SHALL have port timeout_pulse  output  1  one-cycle strobe on a forced release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-011 SHALL, in IDLE with req != 0, select the first set req bit scanning from last_id+1 upward, modulo 5, and enter GRANT on the next edge.
REQ-012 SHALL provide a grant latency of 1 cycle: req sampled high at edge N gives gnt high after edge N.
REQ-013 SHALL update last_id to the granted index on every grant.
REQ-014 SHALL hold gnt, gnt_id and busy constant throughout GRANT regardless of other req changes.
REQ-015 SHALL release, in GRANT, when done[gnt_id] is 1 or req[gnt_id] is 0; gnt becomes 0 after that edge and the FSM returns to IDLE.
REQ-016 SHALL ignore done bits of non-granted requesters.
REQ-017 SHALL insert exactly one IDLE cycle between consecutive grants, including grants to the same requester.
REQ-018 SHALL drive gnt_id to 0 whenever gnt is 0.
REQ-019 SHALL keep busy identical to |gnt.
REQ-020 SHALL never assert more than one gnt bit in any cycle.

Reset
REQ-021 SHALL, when rst_n is 0 at a clock edge, set FSM to IDLE, gnt=0, gnt_id=0, busy=0, timeout_pulse=0, hold counter=0 and last_id=4, so requester 0 has first priority.
REQ-022 SHALL, on reset asserted mid-grant, drop gnt at that edge with no timeout_pulse.
REQ-023 SHALL sample req no earlier than the first edge with rst_n=1; the first grant appears at the following edge.

Configuration
REQ-024 SHALL, with macro ROOT5_ARB_TIMEOUT_EN defined, count the cycles gnt is held (from 1 in the first grant cycle) and force release when the count reaches MAX_HOLD without a normal release, asserting timeout_pulse for exactly the one cycle in which gnt first reads 0.
REQ-025 SHALL, if a normal release and the timeout coincide, treat the event as a normal release (timeout_pulse=0).
REQ-026 SHALL, without ROOT5_ARB_TIMEOUT_EN, omit the counter, hold grants indefinitely and tie timeout_pulse to 0.

Verification
REQ-027 SHALL verify: after reset req=5'b11111 held with done pulsed one cycle in each grant -> grant order 0,1,2,3,4,0 with one idle cycle between grants.
REQ-028 SHALL verify: req=5'b00100 at edge N -> gnt=5'b00100, gnt_id=2, busy=1 after edge N; done[2] high one cycle -> gnt=0 next edge.
REQ-029 SHALL verify: during grant to 1, done=5'b11101 -> grant to 1 unchanged; req[1] dropped -> release next edge.
REQ-030 SHALL verify: rst_n=0 during grant to 3 -> gnt=0, timeout_pulse=0 after that edge; after release req=5'b01000 -> requester 3 granted (last_id=4).
REQ-031 SHALL verify, with ROOT5_ARB_TIMEOUT_EN and MAX_HOLD=4: req[0] held, done=0 -> gnt high for 4 cycles, then gnt=0 with timeout_pulse=1 for one cycle, then requester 0 regranted after one idle cycle.
REQ-032 SHALL verify, with MAX_HOLD=4: done[0] in 4th grant cycle -> release with timeout_pulse=0.
